// File: rtl/if_prefetch_buf.sv
// Instruction-fetch front end: issues sequential word fetches into an in-order
// prefetch queue. It redirects on reboot/jump and drops responses that belong
// to squashed requests.
// DEPTH must be a power of two and at least 2; the queue and pc FIFO pointers
// wrap on their natural width.
module if_prefetch_buf #(
   parameter int unsigned       ADDR_W    = 32,
   parameter int unsigned       DEPTH     = 4,
   parameter logic [ADDR_W-1:0] BOOT_ADDR = '0
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              reboot_i,
   input  logic [ADDR_W-1:0] boot_addr_i,
   input  logic              jump_flag_i,
   input  logic [ADDR_W-1:0] jump_addr_i,
   input  logic              hold_i,
   output logic              imem_req_o,
   output logic [ADDR_W-1:0] imem_addr_o,
   input  logic              imem_gnt_i,
   input  logic              imem_rvalid_i,
   input  logic [31:0]       imem_rdata_i,
   output logic              fetch_valid_o,
   output logic [ADDR_W-1:0] fetch_pc_o,
   output logic [31:0]       fetch_instr_o
);

   localparam int unsigned CW  = $clog2(DEPTH + 1);
   localparam int unsigned PW  = $clog2(DEPTH);
   localparam int unsigned SW  = CW + 2;
   localparam logic [31:0] NOP = 32'h0000_0013;

   // Architectural state
   logic [ADDR_W-1:0] next_pc, next_pc_nxt;
   logic [CW-1:0]     count, count_nxt;
   logic [CW-1:0]     outstanding, outstanding_nxt;
   logic [CW-1:0]     discard, discard_nxt;

   // Prefetch queue storage and pointers
   logic [ADDR_W-1:0] q_pc    [DEPTH];
   logic [31:0]       q_instr [DEPTH];
   logic [PW-1:0]     q_rd, q_rd_nxt;
   logic [PW-1:0]     q_wr, q_wr_nxt;

   // Address of every granted, still-tracked request, oldest first
   logic [ADDR_W-1:0] pcf [DEPTH];
   logic [PW-1:0]     pcf_rd, pcf_rd_nxt;
   logic [PW-1:0]     pcf_wr, pcf_wr_nxt;

   // Registered queue head driving the fetch_* outputs
   logic              head_valid, head_valid_nxt;
   logic [ADDR_W-1:0] head_pc, head_pc_nxt;
   logic [31:0]       head_instr, head_instr_nxt;

   // Per-cycle events
   logic              flush;
   logic              grant;
   logic              push;
   logic              pop;
   logic [ADDR_W-1:0] target;
   logic [ADDR_W-1:0] push_pc;
   logic [SW-1:0]     in_use;
   logic [CW-1:0]     count_after_pop;

   // Redirect decode and request-side handshake
   always_comb begin
      flush   = reboot_i | jump_flag_i;
      target  = reboot_i ? {boot_addr_i[ADDR_W-1:2], 2'b00}
                         : {jump_addr_i[ADDR_W-1:2], 2'b00};
      // Every slot that is queued, in flight or awaiting a drop counts as used,
      // so a response can never find the queue full.
      in_use  = SW'(count) + SW'(outstanding) + SW'(discard);
      imem_req_o  = !flush && (in_use < SW'(DEPTH));
      imem_addr_o = next_pc;
      grant   = imem_req_o & imem_gnt_i;
      push    = imem_rvalid_i & ~flush & (discard == '0);
      pop     = head_valid & ~hold_i & ~flush;
      push_pc = pcf[pcf_rd];
      count_after_pop = count - CW'(pop);
   end

   // Next-state for pointers, counters and fetch address
   always_comb begin
      next_pc_nxt     = next_pc;
      count_nxt       = count;
      outstanding_nxt = outstanding;
      discard_nxt     = discard;
      q_rd_nxt        = q_rd;
      q_wr_nxt        = q_wr;
      pcf_rd_nxt      = pcf_rd;
      pcf_wr_nxt      = pcf_wr;
      if (flush) begin
         next_pc_nxt     = target;
         count_nxt       = '0;
         outstanding_nxt = '0;
         q_rd_nxt        = '0;
         q_wr_nxt        = '0;
         pcf_rd_nxt      = '0;
         pcf_wr_nxt      = '0;
         // Everything still in flight becomes a response to drop; a response
         // arriving now retires one of them.
         discard_nxt     = CW'(SW'(discard) + SW'(outstanding) + SW'(grant)
                               - SW'(imem_rvalid_i));
      end else begin
         if (grant) begin
            next_pc_nxt = next_pc + ADDR_W'(4);
            pcf_wr_nxt  = pcf_wr + PW'(1);
         end
         if (imem_rvalid_i && (discard != '0)) begin
            discard_nxt = discard - CW'(1);
         end
         if (push) begin
            q_wr_nxt   = q_wr + PW'(1);
            pcf_rd_nxt = pcf_rd + PW'(1);
         end
         if (pop) begin
            q_rd_nxt = q_rd + PW'(1);
         end
         outstanding_nxt = outstanding + CW'(grant) - CW'(push);
         count_nxt       = count + CW'(push) - CW'(pop);
      end
   end

   // Next head value; when the queue drains the previous head is kept on the outputs
   always_comb begin
      head_valid_nxt = !flush && (count_nxt != '0);
      head_pc_nxt    = head_pc;
      head_instr_nxt = head_instr;
      if (head_valid_nxt) begin
         if (count_after_pop == '0) begin
            // Queue was empty after the pop: the incoming response becomes head
            head_pc_nxt    = push_pc;
            head_instr_nxt = imem_rdata_i;
         end else begin
            head_pc_nxt    = q_pc[q_rd_nxt];
            head_instr_nxt = q_instr[q_rd_nxt];
         end
      end
   end

   // State registers with synchronous reset
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         next_pc     <= BOOT_ADDR;
         count       <= '0;
         outstanding <= '0;
         discard     <= '0;
         q_rd        <= '0;
         q_wr        <= '0;
         pcf_rd      <= '0;
         pcf_wr      <= '0;
         head_valid  <= 1'b0;
         head_pc     <= BOOT_ADDR;
         head_instr  <= NOP;
      end else begin
         next_pc     <= next_pc_nxt;
         count       <= count_nxt;
         outstanding <= outstanding_nxt;
         discard     <= discard_nxt;
         q_rd        <= q_rd_nxt;
         q_wr        <= q_wr_nxt;
         pcf_rd      <= pcf_rd_nxt;
         pcf_wr      <= pcf_wr_nxt;
         head_valid  <= head_valid_nxt;
         head_pc     <= head_pc_nxt;
         head_instr  <= head_instr_nxt;
      end
   end

   // Queue and pc FIFO storage writes; contents are meaningless until counted valid
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         if (push) begin
            q_pc[q_wr]    <= push_pc;
            q_instr[q_wr] <= imem_rdata_i;
         end
         if (grant) begin
            pcf[pcf_wr] <= next_pc;
         end
      end
   end

   assign fetch_valid_o = head_valid;
   assign fetch_pc_o    = head_pc;
   assign fetch_instr_o = head_instr;

endmodule

// File: tb/tb_if_prefetch_buf.sv
// Randomised bench for if_prefetch_buf: a memory model answers fetches with
// random grant/latency, and a queue-based reference predicts every output.
module tb_if_prefetch_buf;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DEPTH  = 4;
   localparam logic [31:0] BOOT   = 32'h0000_0100;
   localparam logic [31:0] NOP    = 32'h0000_0013;
   localparam int          NCYC   = 6000;

   logic        clk;
   logic        rst;
   logic        reboot;
   logic [31:0] boot_addr;
   logic        jump;
   logic [31:0] jump_addr;
   logic        hold;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        fetch_valid;
   logic [31:0] fetch_pc;
   logic [31:0] fetch_instr;

   if_prefetch_buf #(
      .ADDR_W   (ADDR_W),
      .DEPTH    (DEPTH),
      .BOOT_ADDR(BOOT)
   ) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .reboot_i     (reboot),
      .boot_addr_i  (boot_addr),
      .jump_flag_i  (jump),
      .jump_addr_i  (jump_addr),
      .hold_i       (hold),
      .imem_req_o   (imem_req),
      .imem_addr_o  (imem_addr),
      .imem_gnt_i   (imem_gnt),
      .imem_rvalid_i(imem_rvalid),
      .imem_rdata_i (imem_rdata),
      .fetch_valid_o(fetch_valid),
      .fetch_pc_o   (fetch_pc),
      .fetch_instr_o(fetch_instr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic        stale;
   } req_t;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } ent_t;

   typedef struct {
      logic [31:0] addr;
      int          due;
   } mem_t;

   // Reference model: requests in flight, instructions ready for decode
   req_t        inflight[$];
   ent_t        fq[$];
   ent_t        last;
   logic [31:0] m_next_pc;
   // Memory model: accepted requests awaiting their response
   mem_t        pend[$];

   int n_vec;
   int n_err;
   int cyc;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]} ^ 32'h5A5A_0013;
   endfunction

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic model_reset();
      inflight.delete();
      fq.delete();
      pend.delete();
      m_next_pc   = BOOT;
      last.pc     = BOOT;
      last.instr  = NOP;
   endtask

   initial begin
      int   p_hold, p_gnt, p_jump, p_reboot, p_rv, lat_min, lat_max;
      logic exp_req;
      logic flush;
      logic [31:0] tgt;
      req_t r;
      mem_t m;
      ent_t e;

      n_vec = 0;
      n_err = 0;
      rst = 1'b1; reboot = 1'b0; jump = 1'b0; hold = 1'b0;
      boot_addr = '0; jump_addr = '0; imem_gnt = 1'b0;
      imem_rvalid = 1'b0; imem_rdata = '0;
      model_reset();

      for (cyc = 0; cyc < NCYC; cyc++) begin
         @(posedge clk);
         #1;
         // Phase knobs
         p_hold = 30; p_gnt = 70; p_jump = 4; p_reboot = 1; p_rv = 80;
         lat_min = 1; lat_max = 4;
         if (cyc < 300) begin
            // Single-cycle memory, no stalls: back-to-back stream
            p_hold = 0; p_gnt = 100; p_jump = 0; p_reboot = 0; p_rv = 100; lat_max = 1;
         end else if (cyc < 400) begin
            p_hold = 100; p_jump = 0; p_reboot = 0;
         end else if (cyc >= 3000 && cyc < 3100) begin
            p_jump = 0; p_reboot = 0; p_hold = 10;
         end else if (cyc >= 3900 && cyc < 4200) begin
            p_gnt = 100; p_rv = 100; lat_min = 3; lat_max = 3; p_jump = 1; p_reboot = 0;
         end

         rst       = (cyc < 2) || (cyc == 2000) || ($urandom_range(699) == 0);
         hold      = ($urandom_range(99) < p_hold);
         imem_gnt  = ($urandom_range(99) < p_gnt);
         reboot    = ($urandom_range(99) < p_reboot);
         jump      = ($urandom_range(99) < p_jump);
         boot_addr = $urandom() & 32'hFFFF_FFFC;
         jump_addr = $urandom_range(1) ? $urandom() : (32'hFFFF_FFE0 | ($urandom() & 31));
         if (cyc == 1500) begin
            reboot = 1'b1; jump = 1'b1; boot_addr = 32'h40; jump_addr = 32'h80;
         end
         if (cyc == 3000) begin
            jump = 1'b1; reboot = 1'b0; jump_addr = 32'hFFFF_FFF0;
         end
         if (cyc == 4000) begin
            jump = 1'b1; reboot = 1'b0; jump_addr = 32'h0000_2000;
         end
         if (!rst && pend.size() > 0 && pend[0].due <= cyc && $urandom_range(99) < p_rv) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(pend[0].addr);
         end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom();
         end

         #4;
         // Compare against the model state for this cycle
         flush   = reboot || jump;
         exp_req = !flush && ((fq.size() + inflight.size()) < DEPTH);
         check_val("imem_req", {31'd0, imem_req}, {31'd0, exp_req});
         if (exp_req && imem_req) check_val("imem_addr", imem_addr, m_next_pc);
         check_val("fetch_valid", {31'd0, fetch_valid}, {31'd0, fq.size() > 0});
         if (fq.size() > 0) begin
            check_val("fetch_pc", fetch_pc, fq[0].pc);
            check_val("fetch_instr", fetch_instr, fq[0].instr);
            last = fq[0];
         end else begin
            check_val("idle_pc", fetch_pc, last.pc);
            check_val("idle_instr", fetch_instr, last.instr);
         end

         // Advance memory and reference to the state after the coming edge
         if (rst) begin
            model_reset();
         end else begin
            if (imem_req && imem_gnt) begin
               m.addr = imem_addr;
               m.due  = cyc + $urandom_range(lat_max, lat_min);
               pend.push_back(m);
            end
            r.addr  = '0;
            r.stale = 1'b1;
            if (imem_rvalid) begin
               void'(pend.pop_front());
               if (inflight.size() > 0) r = inflight.pop_front();
            end
            if (flush) begin
               tgt = reboot ? boot_addr : {jump_addr[31:2], 2'b00};
               fq.delete();
               foreach (inflight[i]) inflight[i].stale = 1'b1;
               m_next_pc = tgt;
            end else begin
               if (fq.size() > 0 && !hold) void'(fq.pop_front());
               if (imem_rvalid && !r.stale) begin
                  e.pc    = r.addr;
                  e.instr = mem_word(r.addr);
                  fq.push_back(e);
               end
               if (exp_req && imem_gnt) begin
                  r.addr  = m_next_pc;
                  r.stale = 1'b0;
                  inflight.push_back(r);
                  m_next_pc = m_next_pc + 32'd4;
               end
            end
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
